spi_trig_multi: RTL
===================

Name: spi_trig_multi

Overview:
Parametrised SPI protocol trigger. It oversamples cs/sclk/mosi/miso entirely in the clk domain and supports all four SPI modes. Each completed message is compared against N_PAT independently configurable MOSI/MISO pattern slots. It drives a one-cycle trigger pulse to the acquisition logic, with hold-off and single-shot arming, and exports the captured message for debug readback.

Parameters:
DATA_W, 32, captured message width in bits (8..32)
N_PAT, 4, number of pattern slots (1..8)
CNT_W, 8, bit-counter width; count saturates at 2^CNT_W-1

Ports:
clk  in  1  system clock, >= 5x sclk frequency
rstn  in  1  synchronous, active-low reset
sys_addr  in  32  bus address; decode on sys_addr[19:0]
sys_wdata  in  32  bus write data
sys_wen  in  1  bus write enable
cs  in  1  SPI chip select, active low, asynchronous
sclk  in  1  SPI clock, asynchronous
mosi  in  1  SPI MOSI, asynchronous
miso  in  1  SPI MISO, asynchronous
trg  out  1  one-cycle trigger pulse
trg_hit  out  N_PAT  per-slot match vector, held until next msg_valid
msg_valid  out  1  one-cycle strobe at end of each message
msg_bits  out  CNT_W  number of sclk sample edges in the last message
msg_mosi  out  DATA_W  last DATA_W MOSI bits, LSB = newest bit
msg_miso  out  DATA_W  last DATA_W MISO bits, LSB = newest bit

Behaviour:
- Reset: trg=0, trg_hit=0, msg_valid=0, msg_bits=0, msg_mosi=0, msg_miso=0. Filtered cs = 1 (idle); shift registers, counters and hold-off are cleared. A reset mid-message discards the partial message. If cs is low when reset releases, a new message starts after the filter delay.
- Input path: all four inputs pass through 2-FF synchronisers. mosi and miso get one extra stage so they align with the sclk edge detector.
- cs filter: 3-sample majority on synchronised cs.
  - cs_f falls when 2 of 3 samples are 0: message start. Shift registers and bit counter clear.
  - cs_f rises when 2 of 3 samples are 1: msg_end strobe, one cycle.
- Sample edge: the edge polarity is (CPOL xor CPHA)==0 ? rising : falling on synchronised sclk. An edge is counted only while cs_f==0.
  - On each counted edge, shift mosi/miso in at the LSB. Older bits beyond DATA_W are dropped.
  - The bit counter increments and saturates.
  - An edge in the same cycle as msg_end is ignored.
- Valid-bit mask: vmask = bits [min(count,DATA_W)-1:0] set.
- Slot k matches when all of the following hold:
  - en_k=1 and count != 0;
  - len_k==0 or len_k==count;
  - (mosi_sh xor mosi_pat_k) & mosi_mask_k & vmask == 0;
  - if miso_en_k=1: (miso_sh xor miso_pat_k) & miso_mask_k & vmask == 0.
- Output timing: one cycle after msg_end, msg_valid=1 and trg_hit/msg_* are registered.
- trg: asserted in that same cycle if |hit && armed && holdoff_cnt==0.
  - On trg: load holdoff_cnt=HOLDOFF, which decrements by 1 per clk to 0.
  - On trg with SINGLE=1: clear armed.
  - Hold-off and disarm suppress trg only; trg_hit and msg_* still update.
- Register writes (sys_wen, sys_addr[19:0]) take effect the next cycle. A message is evaluated against the config present at msg_end.
  - 0x60 CTRL: bit0 CPOL, bit1 CPHA, bit2 SINGLE, bit3 ARM. ARM is write-1 to set armed; it is self-clearing and not stored. Reset value 0, armed=1.
  - 0x64 HOLDOFF [31:0] clk cycles. Reset value 0.
  - Slot k base = 0x80 + k*0x20:
    - +0x00 SCTRL: bit0 en, bit1 miso_en, bits[15:8] len.
    - +0x04 mosi_mask.
    - +0x08 mosi_pat.
    - +0x0C miso_mask.
    - +0x10 miso_pat.
    - Pattern and mask registers use bits [DATA_W-1:0].
  - Slot reset values: slot 0 en=1, miso_en=0, len=0, mosi_pat=0x33AA, mosi_mask=all ones, miso=0. Other slots are all zero (disabled).
- Other cases:
  - A message with zero edges still produces msg_valid with msg_bits=0, trg_hit=0, trg=0.
  - count > DATA_W: compare over the last DATA_W bits.
  - Simultaneous ARM write and trg: ARM wins, so armed stays 1.

Test Plan:
- Mode 0, 16-bit MOSI 0x33AA, reset config -> trg=1 for one cycle, within 7 clk of cs pin rise; trg_hit=0001, msg_bits=16, msg_mosi=0x000033AA.
- Mode 3 (CPOL=1, CPHA=1), slot 1 mosi_pat=0xA5, mask=0xFF, len=8, miso_en=1, miso_pat=0x3C; send mosi 0xA5/miso 0x3C, then mosi 0xA5/miso 0x3D -> first message trg_hit=0010 with trg=1; second message trg_hit=0000 with trg=0.
- 40-bit message ending 0x...000033AA, DATA_W=32 -> msg_bits=40, slot 0 hit, trg=1; same message with slot 0 len=16 -> no hit.
- HOLDOFF=1000, three matching messages 200 clk apart -> trg only on the first; trg_hit=0001 on all three; the 4th message 1200 clk later triggers.
- SINGLE=1: two matching messages -> one trg. Write ARM, send another matching message -> trg. Write ARM in the same cycle as a trg -> armed remains 1.
- Reset asserted mid-message after 5 edges, released with cs still low, then 16 edges of 0x33AA -> msg_bits=16, trg=1; cs toggle with no sclk -> msg_valid=1, msg_bits=0, trg=0.

Source files
------------

// File: rtl/spi_trig_multi.sv
// SPI protocol trigger: oversamples cs/sclk/mosi/miso in the clk domain,
// compares each finished message against N_PAT pattern slots and fires a
// one-cycle trigger with hold-off and single-shot arming.

// One pattern slot: its configuration registers plus the match decision.
module spi_trig_slot #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 8,
  parameter bit RST_DEF = 1'b0   // slot comes out of reset matching 0x33AA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wen,
  input  logic [4:0]        off,
  input  logic [31:0]       wdata,
  input  logic [DATA_W-1:0] mosiSh,
  input  logic [DATA_W-1:0] misoSh,
  input  logic [DATA_W-1:0] vmask,
  input  logic [CNT_W-1:0]  count,
  output logic              hit
);
  logic              en, misoEn;
  logic [7:0]        len;
  logic [DATA_W-1:0] mosiMask, mosiPat, misoMask, misoPat;
  logic              lenOk, mosiOk, misoOk;

  // slot configuration registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      en       <= RST_DEF;
      misoEn   <= 1'b0;
      len      <= 8'd0;
      mosiMask <= RST_DEF ? '1 : '0;
      mosiPat  <= RST_DEF ? DATA_W'(32'h33AA) : '0;
      misoMask <= '0;
      misoPat  <= '0;
    end else if (wen) begin
      case (off)
        5'h00: begin
          en     <= wdata[0];
          misoEn <= wdata[1];
          len    <= wdata[15:8];
        end
        5'h04: mosiMask <= wdata[DATA_W-1:0];
        5'h08: mosiPat  <= wdata[DATA_W-1:0];
        5'h0C: misoMask <= wdata[DATA_W-1:0];
        5'h10: misoPat  <= wdata[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  // only bits that were actually shifted in take part in the compare
  assign lenOk  = (len == 8'd0) || (32'(len) == 32'(count));
  assign mosiOk = ((mosiSh ^ mosiPat) & mosiMask & vmask) == '0;
  assign misoOk = !misoEn || (((misoSh ^ misoPat) & misoMask & vmask) == '0);
  assign hit    = en && (count != '0) && lenOk && mosiOk && misoOk;
endmodule

module spi_trig_multi #(
  parameter int DATA_W = 32,
  parameter int N_PAT  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic              sys_wen,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              miso,
  output logic              trg,
  output logic [N_PAT-1:0]  trg_hit,
  output logic              msg_valid,
  output logic [CNT_W-1:0]  msg_bits,
  output logic [DATA_W-1:0] msg_mosi,
  output logic [DATA_W-1:0] msg_miso
);
  localparam int SLOT_END = 'h80 + N_PAT * 'h20;

  logic [19:0]       addr, slotOff;
  logic              ctrlWr, holdWr, armWr, inSlots;
  logic [N_PAT-1:0]  slotWen, hit;
  logic              cpol, cpha, single, armed;
  logic [31:0]       holdoff, holdoffCnt;
  logic [1:0]        csS, sclkS, csH;
  logic              sclkD, csF;
  logic [2:0]        mosiS, misoS;
  logic              csMaj, msgStart, msgEnd, sclkEdge, bitEdge, fire;
  logic [DATA_W-1:0] mosiSh, misoSh, vmask;
  logic [CNT_W-1:0]  count;
  logic              unusedAddr;

  assign addr       = sys_addr[19:0];
  assign unusedAddr = &{1'b0, sys_addr[31:20]};
  assign ctrlWr     = sys_wen && (addr == 20'h60);
  assign holdWr     = sys_wen && (addr == 20'h64);
  assign armWr      = ctrlWr && sys_wdata[3];
  assign inSlots    = sys_wen && (addr >= 20'h80) && (32'(addr) < SLOT_END);
  assign slotOff    = addr - 20'h80;

  // one write strobe per slot, slots are 0x20 apart
  always_comb begin
    slotWen = '0;
    for (int k = 0; k < N_PAT; k++)
      slotWen[k] = inSlots && (32'(slotOff[19:5]) == k);
  end

  // synchronisers; mosi/miso run one stage deeper to line up with sclkD
  always_ff @(posedge clk) begin
    if (!rstn) begin
      csS   <= 2'b11;
      csH   <= 2'b11;
      csF   <= 1'b1;
      sclkS <= 2'b00;
      sclkD <= 1'b0;
      mosiS <= '0;
      misoS <= '0;
    end else begin
      csS   <= {csS[0], cs};
      csH   <= {csH[0], csS[1]};
      csF   <= csMaj;
      sclkS <= {sclkS[0], sclk};
      sclkD <= sclkS[1];
      mosiS <= {mosiS[1:0], mosi};
      misoS <= {misoS[1:0], miso};
    end
  end

  assign csMaj    = (csS[1] & csH[0]) | (csS[1] & csH[1]) | (csH[0] & csH[1]);
  assign msgStart = csF & ~csMaj;
  assign msgEnd   = ~csF & csMaj;
  assign sclkEdge = (cpol ^ cpha) ? (~sclkS[1] & sclkD) : (sclkS[1] & ~sclkD);
  assign bitEdge  = sclkEdge & ~csF & ~msgEnd;

  // message shift registers and saturating bit counter
  always_ff @(posedge clk) begin
    if (!rstn || msgStart) begin
      mosiSh <= '0;
      misoSh <= '0;
      count  <= '0;
    end else if (bitEdge) begin
      mosiSh <= {mosiSh[DATA_W-2:0], mosiS[2]};
      misoSh <= {misoSh[DATA_W-2:0], misoS[2]};
      if (count != '1) count <= count + 1'b1;
    end
  end

  // low min(count, DATA_W) bits are valid
  always_comb begin
    vmask = '0;
    for (int i = 0; i < DATA_W; i++) vmask[i] = (32'(count) > 32'(i));
  end

  for (genvar k = 0; k < N_PAT; k++) begin : gSlot
    spi_trig_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RST_DEF(k == 0)) uSlot (
      .clk(clk), .rstn(rstn), .wen(slotWen[k]), .off(addr[4:0]),
      .wdata(sys_wdata), .mosiSh(mosiSh), .misoSh(misoSh), .vmask(vmask),
      .count(count), .hit(hit[k])
    );
  end

  assign fire = msgEnd && (|hit) && armed && (holdoffCnt == '0);

  // global control, arming and hold-off; an ARM write beats a single-shot disarm
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      single     <= 1'b0;
      armed      <= 1'b1;
      holdoff    <= '0;
      holdoffCnt <= '0;
    end else begin
      if (ctrlWr) {single, cpha, cpol} <= sys_wdata[2:0];
      if (holdWr) holdoff <= sys_wdata;
      if (fire) holdoffCnt <= holdoff;
      else if (holdoffCnt != '0) holdoffCnt <= holdoffCnt - 1'b1;
      if (armWr) armed <= 1'b1;
      else if (fire && single) armed <= 1'b0;
    end
  end

  // registered message result, one cycle after cs_f rises
  always_ff @(posedge clk) begin
    if (!rstn) begin
      msg_valid <= 1'b0;
      trg       <= 1'b0;
      trg_hit   <= '0;
      msg_bits  <= '0;
      msg_mosi  <= '0;
      msg_miso  <= '0;
    end else begin
      msg_valid <= msgEnd;
      trg       <= fire;
      if (msgEnd) begin
        trg_hit  <= hit;
        msg_bits <= count;
        msg_mosi <= mosiSh;
        msg_miso <= misoSh;
      end
    end
  end
endmodule
